// File: rtl/usb_protocol_ctrl_mep.sv
// Multi-endpoint USB protocol controller: sequences OUT/IN transactions, drives handshakes,
// tracks per-endpoint data toggles and aborts stalled transactions with a watchdog.
module usb_protocol_ctrl_mep #(
  parameter int unsigned NUM_EP      = 2,
  parameter int unsigned BUF_DEPTH   = 64,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned EP_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1,
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        rx_packet,
  input  logic [EP_W-1:0]   rx_ep,
  input  logic              buffer_reserved,
  input  logic [OCC_W-1:0]  buffer_occupancy,
  input  logic              tx_status,
  input  logic [NUM_EP-1:0] toggle_clr,
  output logic              rx_data_ready,
  output logic              rx_transfer_active,
  output logic              rx_error,
  output logic              tx_transfer_active,
  output logic              tx_error,
  output logic              timeout_error,
  output logic              d_mode,
  output logic [1:0]        tx_packet,
  output logic              data_pid,
  output logic [EP_W-1:0]   active_ep,
  output logic              clear,
  output logic              lock_db
);

  localparam logic [2:0] RX_OUT   = 3'd1;
  localparam logic [2:0] RX_RCVD  = 3'd2;
  localparam logic [2:0] RX_ERR   = 3'd3;
  localparam logic [2:0] RX_BUSY  = 3'd4;
  localparam logic [2:0] RX_TXERR = 3'd5;
  localparam logic [2:0] RX_IN    = 3'd6;

  localparam logic [1:0] TXP_IDLE = 2'd0;
  localparam logic [1:0] TXP_DATA = 2'd1;
  localparam logic [1:0] TXP_ACK  = 2'd2;
  localparam logic [1:0] TXP_NACK = 2'd3;

  typedef enum logic [3:0] {
    IDLE, RX_ACTIVE, RX_ERROR, PACKET_READY, RX_ACK, RX_NACK, RESERVED, LOCK,
    START_TX, TX_ACTIVE, TX_NACK, TX_ERROR, TIMEOUT, BUFFER_ERROR
  } state_t;

  state_t            state, state_n;
  logic [TO_W-1:0]   timer, timer_n;
  logic [NUM_EP-1:0] toggle, toggle_n, flip;
  logic [EP_W-1:0]   active_ep_n;
  logic              wait_st, ep_valid, overflow, out_or_busy;
  logic              rx_data_ready_n, rx_transfer_active_n, rx_error_n, tx_transfer_active_n;
  logic              tx_error_n, timeout_error_n, d_mode_n, data_pid_n, clear_n, lock_db_n;
  logic [1:0]        tx_packet_n;

  assign ep_valid    = 32'(rx_ep) < NUM_EP;
  assign overflow    = 32'(buffer_occupancy) > BUF_DEPTH;
  assign out_or_busy = (rx_packet == RX_OUT) || (rx_packet == RX_BUSY);

  // Next state, toggle flips and timer; outputs are decoded from the next state.
  always_comb begin
    state_n     = state;
    active_ep_n = active_ep;
    flip        = '0;
    wait_st     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_packet == RX_BUSY && ep_valid) begin
          state_n     = RX_ACTIVE;
          active_ep_n = rx_ep;
        end else if (buffer_reserved) begin
          state_n = RESERVED;
        end else if (rx_packet == RX_IN && ep_valid) begin
          state_n     = START_TX;
          active_ep_n = rx_ep;
        end else if (rx_packet == RX_TXERR) begin
          state_n = TX_ERROR;
        end
      end
      RX_ACTIVE: begin
        wait_st = 1'b1;
        if (rx_packet == RX_ERR)       state_n = RX_ERROR;
        else if (rx_packet == RX_RCVD) state_n = PACKET_READY;
      end
      PACKET_READY: begin
        if (buffer_reserved) begin
          state_n = RX_NACK;
        end else begin
          state_n         = RX_ACK;
          flip[active_ep] = 1'b1;
        end
      end
      RX_ACK, RX_NACK, TX_NACK: begin
        wait_st = 1'b1;
        if (tx_status) state_n = IDLE;
      end
      RESERVED: begin
        if (out_or_busy)           state_n = LOCK;
        else if (!buffer_reserved) state_n = IDLE;
      end
      LOCK: if (!out_or_busy) state_n = RESERVED;
      START_TX: begin
        if (buffer_reserved || buffer_occupancy == '0) state_n = TX_NACK;
        else                                           state_n = TX_ACTIVE;
      end
      TX_ACTIVE: begin
        wait_st = 1'b1;
        if (tx_status) begin
          state_n         = IDLE;
          flip[active_ep] = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A real exit on the last allowed cycle beats the watchdog.
    if (wait_st && state_n == state && timer == TO_W'(TIMEOUT_CYC - 1)) state_n = TIMEOUT;

    if (overflow) begin
      state_n     = BUFFER_ERROR;
      flip        = '0;
      active_ep_n = active_ep;
    end

    timer_n    = (state_n != state || !wait_st) ? '0 : timer + TO_W'(1);
    toggle_n   = (toggle ^ flip) & ~toggle_clr;
    data_pid_n = toggle_n[active_ep_n];

    rx_data_ready_n      = 1'b0;
    rx_transfer_active_n = 1'b0;
    rx_error_n           = 1'b0;
    tx_transfer_active_n = 1'b0;
    tx_error_n           = 1'b0;
    timeout_error_n      = 1'b0;
    d_mode_n             = 1'b0;
    tx_packet_n          = TXP_IDLE;
    clear_n              = 1'b0;
    lock_db_n            = 1'b0;
    case (state_n)
      RX_ACTIVE:    rx_transfer_active_n = 1'b1;
      RX_ERROR:     begin rx_error_n = 1'b1; clear_n = 1'b1; end
      PACKET_READY: rx_data_ready_n = 1'b1;
      RX_ACK:       tx_packet_n = TXP_ACK;
      RX_NACK:      tx_packet_n = TXP_NACK;
      LOCK:         lock_db_n = 1'b1;
      START_TX:     d_mode_n = 1'b1;
      TX_ACTIVE:    begin tx_packet_n = TXP_DATA; tx_transfer_active_n = 1'b1; d_mode_n = 1'b1; end
      TX_NACK:      tx_packet_n = TXP_NACK;
      TX_ERROR:     begin tx_error_n = 1'b1; clear_n = 1'b1; end
      TIMEOUT:      begin timeout_error_n = 1'b1; clear_n = 1'b1; end
      BUFFER_ERROR: clear_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state              <= IDLE;
      timer              <= '0;
      toggle             <= '0;
      active_ep          <= '0;
      data_pid           <= 1'b0;
      rx_data_ready      <= 1'b0;
      rx_transfer_active <= 1'b0;
      rx_error           <= 1'b0;
      tx_transfer_active <= 1'b0;
      tx_error           <= 1'b0;
      timeout_error      <= 1'b0;
      d_mode             <= 1'b0;
      tx_packet          <= TXP_IDLE;
      clear              <= 1'b0;
      lock_db            <= 1'b0;
    end else begin
      state              <= state_n;
      timer              <= timer_n;
      toggle             <= toggle_n;
      active_ep          <= active_ep_n;
      data_pid           <= data_pid_n;
      rx_data_ready      <= rx_data_ready_n;
      rx_transfer_active <= rx_transfer_active_n;
      rx_error           <= rx_error_n;
      tx_transfer_active <= tx_transfer_active_n;
      tx_error           <= tx_error_n;
      timeout_error      <= timeout_error_n;
      d_mode             <= d_mode_n;
      tx_packet          <= tx_packet_n;
      clear              <= clear_n;
      lock_db            <= lock_db_n;
    end
  end

endmodule
